// File: rtl/downsample_tap_accum_if.sv
// Stream bundle between the DownSample multiplier, the tap accumulator and the output writer.
// Carries the product input handshake and the accumulated-sample output handshake.
// master = producer/consumer side (testbench or surrounding pipeline), slave = accumulator.
interface downsample_tap_accum_if #(
    parameter int PROD_WIDTH = 10,
    parameter int OUT_WIDTH  = 10
);
    logic signed [PROD_WIDTH-1:0] in_prod;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_prod, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_prod, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/downsample_tap_accum.sv
// Purpose: sums TAPS signed products per output sample, rounds (half toward +inf), shifts by SHIFT, limits to OUT_WIDTH.
// Latency: last tap accepted in cycle t -> out_valid in cycle t+1.
// Backpressure: non-last taps always accepted; only the last tap stalls while a held output is not taken.
// Build option DOWNSAMPLE_ACC_SAT_EN: clamp the result to the OUT_WIDTH range instead of two's-complement wrap.
module downsample_tap_accum #(
    parameter int PROD_WIDTH = 10,
    parameter int TAPS       = 4,
    parameter int SHIFT      = 2,
    parameter int OUT_WIDTH  = 10
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    input logic                    acc_clr,
    downsample_tap_accum_if.slave  bus
);
    // Accumulator is wide enough to hold TAPS worst-case products without overflow.
    localparam int ACC_W = PROD_WIDTH + $clog2(TAPS);
    // One spare bit so the rounding constant can never wrap the sum.
    localparam int RND_W = ACC_W + 1;
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     sum;
    logic signed [RND_W-1:0]     rounded;
    logic signed [OUT_WIDTH-1:0] result;
    logic [CNT_W-1:0]            tap_cnt;
    logic                        out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_data_q;
    logic                        ready;
    logic                        beat;

    // Only the closing tap needs a free output slot; a slot frees up when the held sample is taken.
    assign ready    = (tap_cnt != LAST_TAP) || !out_valid_q || bus.out_ready;
    assign beat     = bus.in_valid && ready;
    assign prod_ext = {{(ACC_W - PROD_WIDTH){bus.in_prod[PROD_WIDTH-1]}}, bus.in_prod};
    assign sum      = acc + prod_ext;

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (SHIFT - 1));
            assign rounded = ($signed({sum[ACC_W-1], sum}) + HALF) >>> SHIFT;
        end else begin : g_noround
            assign rounded = {sum[ACC_W-1], sum};
        end
    endgenerate

`ifdef DOWNSAMPLE_ACC_SAT_EN
    generate
        if (OUT_WIDTH < RND_W) begin : g_sat
            localparam logic signed [RND_W-1:0] LIM_HI = RND_W'((2 ** (OUT_WIDTH - 1)) - 1);
            localparam logic signed [RND_W-1:0] LIM_LO = ~LIM_HI;
            // Clamp the rounded sum to the representable output range.
            always_comb begin
                result = OUT_WIDTH'(rounded);
                if (rounded > LIM_HI) begin
                    result = OUT_WIDTH'(LIM_HI);
                end else if (rounded < LIM_LO) begin
                    result = OUT_WIDTH'(LIM_LO);
                end
            end
        end else begin : g_nosat
            assign result = OUT_WIDTH'(rounded);
        end
    endgenerate
`else
    // Plain two's-complement truncation / sign extension to the output width.
    assign result = OUT_WIDTH'(rounded);
`endif

    // Tap counting, accumulation, and the single-entry output holding register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc         <= '0;
            tap_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acc_clr) begin
                // A beat arriving with the clear opens the new group, even if it would have closed the old one.
                acc     <= beat ? prod_ext : '0;
                tap_cnt <= beat ? CNT_W'(1) : '0;
            end else if (beat) begin
                if (tap_cnt == LAST_TAP) begin
                    acc         <= '0;
                    tap_cnt     <= '0;
                    out_data_q  <= result;
                    out_valid_q <= 1'b1;
                end else begin
                    acc     <= sum;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_downsample_tap_accum.sv
// Bench for downsample_tap_accum: two instances (SHIFT=2 and SHIFT=0) share one stimulus stream.
// A product-list reference model predicts in_ready, out_valid and out_data every cycle.
// Directed groups follow the test plan, then a long randomized run with clears, resets and backpressure.
module tb_downsample_tap_accum;
    localparam int PW   = 10;
    localparam int OW   = 10;
    localparam int TAPS = 4;

    logic clk = 1'b0;
    logic ap_rst;
    logic acc_clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: products of the open group and the held output of each instance.
    int grp[$];
    bit have;
    int exp_d2;
    int exp_d0;

    downsample_tap_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) ifc2 ();
    downsample_tap_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) ifc0 ();

    downsample_tap_accum #(.PROD_WIDTH(PW), .TAPS(TAPS), .SHIFT(2), .OUT_WIDTH(OW)) dut2 (
        .ap_clk (clk),
        .ap_rst (ap_rst),
        .acc_clr(acc_clr),
        .bus    (ifc2.slave)
    );

    downsample_tap_accum #(.PROD_WIDTH(PW), .TAPS(TAPS), .SHIFT(0), .OUT_WIDTH(OW)) dut0 (
        .ap_clk (clk),
        .ap_rst (ap_rst),
        .acc_clr(acc_clr),
        .bus    (ifc0.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Floor-division rounding and output limiting, straight from the arithmetic definition.
    function automatic int model_res(input int sum, input int sh);
        int d, q, r;
        if (sh == 0) begin
            r = sum;
        end else begin
            d = 1 << sh;
            q = sum + d / 2;
            r = (q >= 0) ? q / d : -((-q + d - 1) / d);
        end
`ifdef DOWNSAMPLE_ACC_SAT_EN
        if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
        if (r < -(1 << (OW - 1)))    r = -(1 << (OW - 1));
`else
        r = ((r % (1 << OW)) + (1 << OW)) % (1 << OW);
        if (r >= (1 << (OW - 1))) r = r - (1 << OW);
`endif
        return r;
    endfunction

    function automatic int obs_data2();
        return int'($signed(ifc2.out_data));
    endfunction

    function automatic int obs_data0();
        return int'($signed(ifc0.out_data));
    endfunction

    // One clock: drive inputs after the falling edge, check against the model, then advance the model.
    task automatic cyc(input bit rst, input bit clr, input bit vld, input int p, input bit ordy);
        bit exp_rdy, beat;
        int s;
        @(negedge clk);
        ap_rst         = rst;
        acc_clr        = clr;
        ifc2.in_valid  = vld;
        ifc2.in_prod   = PW'(p);
        ifc2.out_ready = ordy;
        ifc0.in_valid  = vld;
        ifc0.in_prod   = PW'(p);
        ifc0.out_ready = ordy;
        #1;
        exp_rdy = (grp.size() != TAPS - 1) || !have || ordy;
        chk("in_ready",   int'(ifc2.in_ready),  int'(exp_rdy));
        chk("in_ready0",  int'(ifc0.in_ready),  int'(exp_rdy));
        chk("out_valid",  int'(ifc2.out_valid), int'(have));
        chk("out_valid0", int'(ifc0.out_valid), int'(have));
        chk("out_data",   obs_data2(), exp_d2);
        chk("out_data0",  obs_data0(), exp_d0);
        if (rst) begin
            grp.delete();
            have   = 1'b0;
            exp_d2 = 0;
            exp_d0 = 0;
        end else begin
            beat = vld && exp_rdy;
            if (have && ordy) have = 1'b0;
            if (clr) begin
                grp.delete();
                if (beat) grp.push_back(p);
            end else if (beat) begin
                grp.push_back(p);
                if (grp.size() == TAPS) begin
                    s = 0;
                    foreach (grp[i]) s += grp[i];
                    exp_d2 = model_res(s, 2);
                    exp_d0 = model_res(s, 0);
                    have   = 1'b1;
                    grp.delete();
                end
            end
        end
    endtask

    task automatic group4(input int a, input int b, input int c, input int d);
        cyc(0, 0, 1, a, 1);
        cyc(0, 0, 1, b, 1);
        cyc(0, 0, 1, c, 1);
        cyc(0, 0, 1, d, 1);
    endtask

    task automatic idle(input bit ordy);
        cyc(0, 0, 0, 0, ordy);
    endtask

    initial begin
        int sel, p;
        ap_rst = 1'b1;
        acc_clr = 1'b0;
        ifc2.in_valid = 1'b0; ifc2.in_prod = '0; ifc2.out_ready = 1'b1;
        ifc0.in_valid = 1'b0; ifc0.in_prod = '0; ifc0.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        grp.delete();
        have = 1'b0; exp_d2 = 0; exp_d0 = 0;

        // Reset state with reset released.
        idle(1);
        chk("rst_valid", int'(ifc2.out_valid), 0);
        chk("rst_data",  obs_data2(), 0);
        chk("rst_ready", int'(ifc2.in_ready), 1);

        // Basic group, back to back.
        group4(100, 200, -50, 30);
        idle(1);
        chk("g1_valid", int'(ifc2.out_valid), 1);
        chk("g1_data",  obs_data2(), 70);

        // Rounding of small negative and positive sums.
        group4(-3, -3, 0, 0);
        idle(1);
        chk("neg_round", obs_data2(), -1);
        group4(1, 1, 0, 0);
        idle(1);
        chk("pos_round", obs_data2(), 1);

        // Extremes: SHIFT=0 instance overflows the output range.
        group4(511, 511, 511, 511);
        idle(1);
        chk("max_s2", obs_data2(), 511);
`ifdef DOWNSAMPLE_ACC_SAT_EN
        chk("max_s0_sat", obs_data0(), 511);
`else
        chk("max_s0_wrap", obs_data0(), -4);
`endif
        group4(-512, -512, -512, -512);
        idle(1);
        chk("min_s2", obs_data2(), -512);

        // Backpressure: group A held, B's last tap stalls until the output is taken.
        repeat (4) cyc(0, 0, 1, 10, 0);
        repeat (3) cyc(0, 0, 1, 20, 0);
        cyc(0, 0, 1, 20, 0);
        chk("bp_stall_rdy", int'(ifc2.in_ready), 0);
        chk("bp_hold_data", obs_data2(), 10);
        cyc(0, 0, 1, 20, 0);
        cyc(0, 0, 1, 20, 1);
        chk("bp_release_rdy", int'(ifc2.in_ready), 1);
        idle(0);
        chk("bp_b_valid", int'(ifc2.out_valid), 1);
        chk("bp_b_data",  obs_data2(), 20);
        idle(1);

        // Reset mid-group drops the partial sum.
        cyc(0, 0, 1, 7, 1);
        cyc(0, 0, 1, 7, 1);
        cyc(1, 0, 0, 0, 1);
        idle(1);
        chk("midrst_valid", int'(ifc2.out_valid), 0);
        group4(4, 4, 4, 4);
        idle(1);
        chk("post_rst_data", obs_data2(), 4);

        // Clear with a beat: that beat starts the new group.
        repeat (3) cyc(0, 0, 1, 100, 1);
        cyc(0, 1, 1, 8, 1);
        repeat (3) cyc(0, 0, 1, 8, 1);
        idle(1);
        chk("clr_data",  obs_data2(), 8);
        idle(1);
        chk("clr_single", int'(ifc2.out_valid), 0);

        // Randomized traffic with gaps, backpressure, clears and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      p = 511;
            else if (sel == 1) p = -512;
            else               p = int'($urandom_range(0, 1023)) - 512;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 7),
                p,
                ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
